// File: rtl/cp0_regs_if.sv
// cp0_regs_if: pipeline-to-CP0 bus (M-stage exception inputs, mtc0/mfc0 access, redirect outputs).
`default_nettype none

interface cp0_regs_if;
  logic [31:0] M_PC;
  logic        M_BD;
  logic [4:0]  M_ExcCode;
  logic        M_eret;
  logic [5:0]  HWInt;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        req;
  logic [31:0] EPC;

  modport master (
    output M_PC, M_BD, M_ExcCode, M_eret, HWInt, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, req, EPC
  );

  modport slave (
    input  M_PC, M_BD, M_ExcCode, M_eret, HWInt, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, req, EPC
  );
endinterface

`default_nettype wire

// File: rtl/cp0_regs.sv
// cp0_regs: CP0 SR/Cause/EPC/PRId register file with exception/interrupt request logic.
// Optional macro CP0_EPC_BYPASS_EN forwards an in-flight mtc0 EPC value to the EPC output.
`default_nettype none

module cp0_regs #(
  parameter logic [31:0] PRID = 32'h2021_1120
) (
  input wire logic   clk,
  input wire logic   reset,
  cp0_regs_if.slave  bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc_q;

  logic        int_req;
  logic        exc_req;
  logic        take;
  logic [31:0] victim_pc;
  logic        unused_wdata;

  assign int_req   = (|(bus.HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req   = (bus.M_ExcCode != 5'd0) & ~sr_exl;
  assign take      = int_req | exc_req;
  assign bus.req   = take;
  // A delay-slot victim restarts at its branch so the branch is re-executed.
  assign victim_pc = bus.M_BD ? (bus.M_PC - 32'd4) : bus.M_PC;

  assign unused_wdata = ^{bus.cp0_wdata[31:16], bus.cp0_wdata[9:2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      cause_ip <= bus.HWInt;
      if (take) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : bus.M_ExcCode;
        cause_bd  <= bus.M_BD;
        epc_q     <= victim_pc & ~32'h3;
      end else begin
        if (bus.cp0_we) begin
          case (bus.cp0_addr)
            5'd12: begin
              sr_im  <= bus.cp0_wdata[15:10];
              sr_exl <= bus.cp0_wdata[1];
              sr_ie  <= bus.cp0_wdata[0];
            end
            5'd14:   epc_q <= bus.cp0_wdata;
            default: ;
          endcase
        end
        if (bus.M_eret) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.cp0_rdata = 32'd0;
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      5'd13:   bus.cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = PRID;
      default: bus.cp0_rdata = 32'd0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign bus.EPC = (bus.cp0_we && (bus.cp0_addr == 5'd14) && !take) ? bus.cp0_wdata : epc_q;
`else
  assign bus.EPC = epc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed self-checking bench for cp0_regs.
`default_nettype none

module tb_cp0_regs;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  cp0_regs_if bus ();

  cp0_regs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.cp0_addr = addr;
    #1;
    check(tag, bus.cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    bus.cp0_we    = 1'b1;
    bus.cp0_addr  = addr;
    bus.cp0_wdata = data;
    tick();
    bus.cp0_we    = 1'b0;
    bus.cp0_wdata = 32'd0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.M_PC = 32'd0;
    bus.M_BD = 1'b0;
    bus.M_ExcCode = 5'd0;
    bus.M_eret = 1'b0;
    bus.HWInt = 6'h3F;
    bus.cp0_we = 1'b0;
    bus.cp0_addr = 5'd0;
    bus.cp0_wdata = 32'd0;
    #1;
    check("rst_req", {31'd0, bus.req}, 32'd0);
    check("rst_epc", bus.EPC, 32'd0);
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc_rd", 5'd14, 32'd0);
    rd("rst_prid", 5'd15, 32'h2021_1120);
    tick();
    reset = 1'b0;
    tick();
    rd("ip_after_rst", 5'd13, 32'h0000_FC00);

    // enable IM[0] and IE
    bus.HWInt = 6'd0;
    mtc0(5'd12, 32'h0000_0401);
    rd("sr_write", 5'd12, 32'h0000_0401);
    check("no_req_idle", {31'd0, bus.req}, 32'd0);

    // interrupt on line 0
    bus.HWInt = 6'd1;
    bus.M_PC = 32'h3010;
    bus.M_BD = 1'b0;
    #1;
    check("int_req", {31'd0, bus.req}, 32'd1);
    tick();
    check("int_masked", {31'd0, bus.req}, 32'd0);
    check("int_epc", bus.EPC, 32'h3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);

    // nested exception masked while EXL=1
    bus.M_ExcCode = 5'd5;
    #1;
    check("exl_mask_exc", {31'd0, bus.req}, 32'd0);
    bus.M_ExcCode = 5'd0;

    // eret with interrupt still pending
    bus.M_eret = 1'b1;
    tick();
    bus.M_eret = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    check("eret_pending_req", {31'd0, bus.req}, 32'd1);
    bus.HWInt = 6'd0;
    #1;
    check("int_dropped", {31'd0, bus.req}, 32'd0);

    // synchronous exception in delay slot
    bus.M_ExcCode = 5'd10;
    bus.M_PC = 32'h3024;
    bus.M_BD = 1'b1;
    #1;
    check("exc_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.M_ExcCode = 5'd0;
    bus.M_BD = 1'b0;
    check("exc_epc", bus.EPC, 32'h3020);
    rd("exc_cause", 5'd13, 32'h8000_0028);
    bus.M_eret = 1'b1;
    tick();
    bus.M_eret = 1'b0;
    rd("eret2_sr", 5'd12, 32'h0000_0401);

    // interrupt + exception + mtc0 in one cycle
    bus.HWInt = 6'd1;
    bus.M_ExcCode = 5'd4;
    bus.M_PC = 32'h3100;
    bus.cp0_we = 1'b1;
    bus.cp0_addr = 5'd14;
    bus.cp0_wdata = 32'hDEAD_BEEF;
    #1;
    check("both_req", {31'd0, bus.req}, 32'd1);
    check("both_epc_nobypass", bus.EPC, 32'h3020);
    tick();
    bus.cp0_we = 1'b0;
    bus.M_ExcCode = 5'd0;
    bus.HWInt = 6'd0;
    check("both_epc", bus.EPC, 32'h3100);
    rd("both_cause", 5'd13, 32'h0000_0400);
    bus.M_eret = 1'b1;
    tick();
    bus.M_eret = 1'b0;

    // writes to Cause and PRId are ignored; unimplemented reads 0
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h0000_0000);
    mtc0(5'd15, 32'h1234_5678);
    rd("prid_ro", 5'd15, 32'h2021_1120);
    rd("unimpl", 5'd3, 32'd0);

    // EPC write with optional bypass
    bus.cp0_we = 1'b1;
    bus.cp0_addr = 5'd14;
    bus.cp0_wdata = 32'h3400;
    #1;
`ifdef CP0_EPC_BYPASS_EN
    check("epc_same_cycle", bus.EPC, 32'h3400);
`else
    check("epc_same_cycle", bus.EPC, 32'h3100);
`endif
    check("epc_rdata_reg", bus.cp0_rdata, 32'h3100);
    tick();
    bus.cp0_we = 1'b0;
    check("epc_after_edge", bus.EPC, 32'h3400);

    // PC wrap in delay slot
    bus.M_PC = 32'd0;
    bus.M_BD = 1'b1;
    bus.M_ExcCode = 5'd12;
    tick();
    bus.M_ExcCode = 5'd0;
    bus.M_BD = 1'b0;
    check("wrap_epc", bus.EPC, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0030);

    // SR writes keep only IM/EXL/IE
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("sr_mask", 5'd12, 32'h0000_FC03);

    // async reset mid-exception
    #2;
    reset = 1'b1;
    #1;
    check("async_epc", bus.EPC, 32'd0);
    rd("async_sr", 5'd12, 32'd0);
    check("async_req", {31'd0, bus.req}, 32'd0);
    tick();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/cp0_regs.md
# cp0_regs

Coprocessor-0 register file and exception/interrupt controller for the 5-stage MIPS pipeline. It evaluates exceptions and external interrupts against the instruction in M, and raises `req` so the pipeline flushes and redirects fetch to the handler. It captures the victim PC into EPC and supplies EPC to the next-PC logic for `eret`. It also serves `mtc0`/`mfc0` for SR(12), Cause(13), EPC(14) and PRId(15).

## Interface
- `PRID`, 32'h2021_1120, constant value returned for register 15.
- `clk`  in  1  pipeline clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `M_PC`  in  32  PC of the instruction currently in M.
- `M_BD`  in  1  M instruction sits in a branch/jump delay slot.
- `M_ExcCode`  in  5  synchronous exception code of the M instruction; 0 = none.
- `M_eret`  in  1  M instruction is `eret`.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `cp0_we`  in  1  `mtc0` in M.
- `cp0_addr`  in  5  CP0 register number for read and write.
- `cp0_wdata`  in  32  `mtc0` data (forwarded rt value).
- `cp0_rdata`  out  32  `mfc0` read data.
- `req`  out  1  take exception/interrupt this cycle: flush F/D/E/M, fetch 0x0000_4180 next.
- `EPC`  out  32  return address for `eret`.

## Operation
- SR fields: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
- Cause fields: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
- IntReq = (|(HWInt & SR.IM)) & SR.IE & ~SR.EXL.
- ExcReq = (M_ExcCode != 0) & ~SR.EXL.
- `req` = IntReq | ExcReq, combinational.
- Priority at each rising edge, highest first:
  - `req`:
    - SR.EXL<=1.
    - Cause.ExcCode <= IntReq ? 0 : M_ExcCode (interrupt wins over a simultaneous exception).
    - Cause.BD<=M_BD.
    - EPC <= (M_BD ? M_PC-4 : M_PC) with bits [1:0] forced to 0.
    - A concurrent `cp0_we` is dropped, because the writing instruction is the victim.
  - `cp0_we`:
    - addr 12 writes IM/EXL/IE.
    - addr 14 writes all 32 bits.
    - Writes to 13, 15 or any other address are ignored.
  - `M_eret` (with no `req`): SR.EXL<=0. `eret` with `cp0_we` in the same cycle cannot occur; if it does, both updates apply.
- Cause.IP <= HWInt every cycle, independent of all of the above.
- `cp0_rdata` is a combinational read of the current register by `cp0_addr`; addr 15 returns PRID; unimplemented addresses return 0.
- Arithmetic: M_PC-4 is modulo 2^32. M_PC=0 with BD gives 0xFFFF_FFFC.

## Timing
- Reset (async): SR=0, Cause=0, EPC=0. Outputs after reset: `req`=0 (IE=0, and ExcCode=0 is expected), `cp0_rdata`=read of the zeroed registers, `EPC`=0.
- `req` has zero-cycle latency from M inputs. Handler fetch occurs the following cycle.
- SR/Cause/EPC updates are visible one cycle after the edge that writes them.
- While EXL=1, `req` stays 0 regardless of HWInt or M_ExcCode, so nested exceptions are masked.
- After `eret` clears EXL, a still-pending interrupt raises `req` in the next cycle the IE/IM conditions hold.
- Reset asserted mid-exception clears EXL and EPC immediately; `req` drops asynchronously.

## Configuration
- `CP0_EPC_BYPASS_EN`
  - Defined: when `cp0_we` && `cp0_addr`==14 && !`req`, the `EPC` output is `cp0_wdata` combinationally, so an `eret` reaching D while `mtc0 EPC` is in M targets the new value without a stall.
  - Undefined: `EPC` is the registered value only, and the hazard unit must stall `eret` in D while `mtc0 EPC` is in E or M.
  - `cp0_rdata` is unaffected either way.

## Test plan
- Reset with HWInt=6'h3F and M_ExcCode=0 -> `req`=0; `mfc0` 12/13/14 read 0 and 15 reads 32'h2021_1120; Cause.IP reads 6'h3F one cycle after reset release.
- `mtc0` SR=32'h0000_0401, then HWInt[0]=1 with M_PC=0x3010 and M_BD=0 -> `req`=1 that cycle. Next cycle: EPC=0x3010, Cause.ExcCode=0, SR.EXL=1, `req`=0.
- M_ExcCode=5'd10 with M_PC=0x3024 and M_BD=1 -> `req`=1. Next cycle: EPC=0x3020, Cause.BD=1, ExcCode=10.
- Interrupt and M_ExcCode=4 in the same cycle -> Cause.ExcCode=0; `mtc0` in that cycle is not applied.
- With EXL=1, M_eret=1 -> EXL=0 next cycle; a pending enabled HWInt raises `req` the cycle after.
- With `CP0_EPC_BYPASS_EN` defined, `mtc0` EPC=0x3400 -> `EPC` output reads 0x3400 in the same cycle. With the macro undefined, the output reads 0x3400 only after the edge.
